// File: rtl/zigzag_pkg.sv
// ============================================================================
// Module   : zigzag_pkg
// Brief    : Block geometry and JPEG zigzag scan table (zigzag -> raster index).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package zigzag_pkg;

  localparam int BLK_N = 64;

  // Entry k holds the raster index 8r+c of zigzag position k.
  localparam logic [5:0] ZZ [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_raster(input logic [5:0] k);
    return ZZ[k];
  endfunction

endpackage

`default_nettype wire

// File: rtl/zigzag_eob_scan.sv
// ============================================================================
// Module   : zigzag_eob_scan
// Brief    : Combinational finder of the last nonzero zigzag position of a
//            raster-ordered block (0 when the block is all zero).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module zigzag_eob_scan
  import zigzag_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic [BLK_N*COEF_W-1:0] block,
  output logic [5:0]              last_pos
);

  // Ascending scan: the highest nonzero zigzag position overwrites earlier ones.
  always_comb begin
    last_pos = '0;
    for (int k = 0; k < BLK_N; k++) begin
      if (block[COEF_W*zz_raster(6'(k)) +: COEF_W] != '0) begin
        last_pos = 6'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/zigzag_stream_buffer.sv
// ============================================================================
// Module   : zigzag_stream_buffer
// Brief    : Ping-pong 8x8 block buffer that streams coefficients out in JPEG
//            zigzag order, one per beat, with index and last flags.
// Config   : define ZIGZAG_EOB_EN to end each block at its last nonzero beat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module zigzag_stream_buffer
  import zigzag_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLK_N*COEF_W-1:0] in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COEF_W-1:0]       out_coef,
  output logic [5:0]              out_idx,
  output logic                    out_last
);

  logic [COEF_W-1:0] r_bank [2][BLK_N];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [5:0]        r_cnt;

  logic              w_accept;
  logic              w_beat;
  logic [5:0]        w_last_pos;

  assign in_ready  = !r_full[r_wr_bank] && !rst;
  assign out_valid = r_full[r_rd_bank];
  assign w_accept  = in_valid && in_ready;
  assign w_beat    = out_valid && out_ready;

`ifdef ZIGZAG_EOB_EN
  logic [5:0] w_scan_pos;
  logic [5:0] r_last_pos [2];

  zigzag_eob_scan #(
    .COEF_W (COEF_W)
  ) u_eob_scan (
    .block    (in_block),
    .last_pos (w_scan_pos)
  );

  // Per-bank end position is metadata only; it is read only while the bank is full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_last_pos[r_wr_bank] <= w_scan_pos;
    end
  end

  assign w_last_pos = r_last_pos[r_rd_bank];
`else
  assign w_last_pos = 6'd63;
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < BLK_N; i++) begin
        r_bank[r_wr_bank][i] <= in_block[COEF_W*i +: COEF_W];
      end
    end
  end

  // Accept and release always target different banks, so both may fire together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_beat) begin
        if (out_last) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
          r_cnt             <= '0;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

  assign out_idx  = r_cnt;
  assign out_last = out_valid && (r_cnt == w_last_pos);
  assign out_coef = out_valid ? r_bank[r_rd_bank][zz_raster(r_cnt)] : '0;

endmodule

`default_nettype wire
